// File: rtl/regfile_sb_if.sv
// Decode/write-back bus for regfile_sb: read ports, write-back, issue and scoreboard status.
interface regfile_sb_if #(
  parameter int N_ADDR = 5,
  parameter int N_BIT  = 32,
  parameter int N_RD   = 2
);
  logic [N_RD*N_ADDR-1:0] Rd_addr;
  logic [N_RD*N_BIT-1:0]  Rd_data;
  logic [N_RD-1:0]        Rd_busy;
  logic                   Wr_en;
  logic [N_ADDR-1:0]      Wr_addr;
  logic [N_BIT-1:0]       Wr_data;
  logic                   Iss_en;
  logic [N_ADDR-1:0]      Iss_addr;
  logic                   Ready;
  logic [N_ADDR:0]        Pend_cnt;

  modport master (
    output Rd_addr, Wr_en, Wr_addr, Wr_data, Iss_en, Iss_addr,
    input  Rd_data, Rd_busy, Ready, Pend_cnt
  );

  modport slave (
    input  Rd_addr, Wr_en, Wr_addr, Wr_data, Iss_en, Iss_addr,
    output Rd_data, Rd_busy, Ready, Pend_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-read-port register file with pending-write scoreboard and post-reset clearing sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data onto matching read ports.
module regfile_sb #(
  parameter int N_ADDR = 5,
  parameter int N_REG  = 2**N_ADDR,
  parameter int N_BIT  = 32,
  parameter int N_RD   = 2
) (
  input  logic         Clk,
  input  logic         Rst,
  regfile_sb_if.slave  bus
);

  typedef enum logic {SWEEP, RUN} state_t;

  localparam logic [N_ADDR-1:0] LAST_PTR = N_ADDR'(N_REG - 1);

  state_t              state_reg, state_next;
  logic [N_ADDR-1:0]   ptr_reg, ptr_next;
  logic [N_REG-1:0]    pend_reg, pend_next;
  logic [N_ADDR:0]     cnt_reg, cnt_next;

  logic [N_BIT-1:0]    bank [N_REG];
  logic                bank_we;
  logic [N_ADDR-1:0]   bank_waddr;
  logic [N_BIT-1:0]    bank_wdata;

  logic                wr_ok, iss_ok, cnt_inc, cnt_dec;
  logic [N_RD*N_BIT-1:0] rd_data_all;
  logic [N_RD-1:0]       rd_busy_all;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg <= SWEEP;
      ptr_reg   <= '0;
      pend_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      pend_reg  <= pend_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    pend_next  = pend_reg;
    bank_we    = 1'b0;
    bank_waddr = bus.Wr_addr;
    bank_wdata = bus.Wr_data;

    wr_ok  = (state_reg == RUN) && bus.Wr_en  && (bus.Wr_addr  != '0);
    iss_ok = (state_reg == RUN) && bus.Iss_en && (bus.Iss_addr != '0);

    // A same-address issue re-arms the bit, so a write-back then does not retire it.
    cnt_inc = iss_ok && !pend_reg[bus.Iss_addr];
    cnt_dec = wr_ok && pend_reg[bus.Wr_addr] && !(iss_ok && (bus.Iss_addr == bus.Wr_addr));

    case (state_reg)
      SWEEP: begin
        bank_we    = 1'b1;
        bank_waddr = ptr_reg;
        bank_wdata = '0;
        ptr_next   = ptr_reg + 1'b1;
        if (ptr_reg == LAST_PTR)
          state_next = RUN;
      end
      RUN: begin
        bank_we = wr_ok;
        if (wr_ok)
          pend_next[bus.Wr_addr] = 1'b0;
        if (iss_ok)
          pend_next[bus.Iss_addr] = 1'b1;
      end
      default: state_next = SWEEP;
    endcase

    cnt_next = cnt_reg + (N_ADDR+1)'(cnt_inc) - (N_ADDR+1)'(cnt_dec);
  end

  // Single write port and no global clear, so the array can map onto RAM.
  always_ff @(posedge Clk) begin
    if (bank_we && !Rst)
      bank[bank_waddr] <= bank_wdata;
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_RD; gi++) begin : g_rd
      logic [N_ADDR-1:0] rd_addr;
      logic [N_BIT-1:0]  rd_data;
      logic              rd_busy;

      assign rd_addr = bus.Rd_addr[gi*N_ADDR +: N_ADDR];

      always_comb begin
        rd_data = '0;
        rd_busy = 1'b0;
        if ((state_reg == RUN) && (rd_addr != '0)) begin
          rd_data = bank[rd_addr];
          rd_busy = pend_reg[rd_addr];
`ifdef REGFILE_BYPASS_EN
          if (wr_ok && (bus.Wr_addr == rd_addr)) begin
            rd_data = bus.Wr_data;
            rd_busy = 1'b0;
          end
`endif
        end
      end

      assign rd_data_all[gi*N_BIT +: N_BIT] = rd_data;
      assign rd_busy_all[gi]                = rd_busy;
    end
  endgenerate

  assign bus.Rd_data  = rd_data_all;
  assign bus.Rd_busy  = rd_busy_all;
  assign bus.Ready    = (state_reg == RUN);
  assign bus.Pend_cnt = cnt_reg;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed, table-driven bench for regfile_sb: sweep, zero register, scoreboard, bypass and resets.
module tb_regfile_sb;

  logic Clk;
  logic Rst;
  int   checks   = 0;
  int   failures = 0;

  regfile_sb_if #(.N_ADDR(5), .N_BIT(32), .N_RD(2)) bus ();

  regfile_sb #(.N_ADDR(5), .N_REG(32), .N_BIT(32), .N_RD(2)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        wr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iss;
    logic [4:0]  ia;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  busy;
    logic [5:0]  cnt;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.Wr_en    = 1'b0;
    bus.Wr_addr  = '0;
    bus.Wr_data  = '0;
    bus.Iss_en   = 1'b0;
    bus.Iss_addr = '0;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    bus.Rd_addr = {a1, a0};
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.Ready && n < 100) begin
      step();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;

    vecs[0]  = '{1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 5'd0,  5'd7,  5'd0,  32'hDEADBEEF, 32'h0,        2'b00, 6'd0};
    vecs[1]  = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0,  5'd0,  5'd7,  32'h0,        32'hDEADBEEF, 2'b00, 6'd0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd3,  5'd3,  32'h0,        32'h0,        2'b11, 6'd1};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd3,  5'd7,  32'h0,        32'hDEADBEEF, 2'b01, 6'd1};
    vecs[4]  = '{1'b1, 5'd3,  32'h00000055, 1'b0, 5'd0,  5'd3,  5'd3,  32'h55,       32'h55,       2'b00, 6'd0};
    vecs[5]  = '{1'b1, 5'd3,  32'h00000077, 1'b0, 5'd0,  5'd3,  5'd0,  32'h77,       32'h0,        2'b00, 6'd0};
    vecs[6]  = '{1'b1, 5'd9,  32'h000000A5, 1'b1, 5'd9,  5'd9,  5'd9,  32'hA5,       32'hA5,       2'b11, 6'd1};
    vecs[7]  = '{1'b1, 5'd9,  32'h0000005A, 1'b1, 5'd9,  5'd9,  5'd3,  32'h5A,       32'h77,       2'b01, 6'd1};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  5'd9,  32'h0,        32'h5A,       2'b10, 6'd1};
    vecs[9]  = '{1'b1, 5'd9,  32'h00000066, 1'b0, 5'd0,  5'd9,  5'd3,  32'h66,       32'h77,       2'b00, 6'd0};
    vecs[10] = '{1'b1, 5'd7,  32'h00000001, 1'b1, 5'd12, 5'd12, 5'd7,  32'h0,        32'h1,        2'b01, 6'd1};
    vecs[11] = '{1'b1, 5'd12, 32'h0000ABCD, 1'b1, 5'd13, 5'd12, 5'd13, 32'hABCD,     32'h0,        2'b10, 6'd1};
    vecs[12] = '{1'b1, 5'd13, 32'h00000013, 1'b0, 5'd0,  5'd13, 5'd12, 32'h13,       32'hABCD,     2'b00, 6'd0};

    // Reset and the first sweep, with write/issue traffic that must be ignored.
    Rst = 1'b1;
    idle();
    set_rd(5'd5, 5'd5);
    step();
    check("rst_ready", {31'b0, bus.Ready}, 32'd0);
    check("rst_pend_cnt", {26'b0, bus.Pend_cnt}, 32'd0);
    check("rst_busy", {30'b0, bus.Rd_busy}, 32'd0);
    check("rst_data", bus.Rd_data[31:0], 32'd0);
    Rst = 1'b0;
    bus.Wr_en = 1'b1; bus.Wr_addr = 5'd5; bus.Wr_data = 32'hFFFF_FFFF;
    bus.Iss_en = 1'b1; bus.Iss_addr = 5'd6;
    n = 0;
    while (!bus.Ready && n < 100) begin
      check("sweep_x5_data", bus.Rd_data[31:0], 32'd0);
      step();
      n++;
    end
    check("sweep_len", n, 32'd32);
    idle();
    set_rd(5'd5, 5'd6);
    #1;
    check("sweep_wr_ignored", bus.Rd_data[31:0], 32'd0);
    check("sweep_iss_ignored", {30'b0, bus.Rd_busy}, 32'd0);
    check("sweep_pend_cnt", {26'b0, bus.Pend_cnt}, 32'd0);
    $display("sweep: ready after %0d cycles", n);

    // Table of single-cycle transactions; outputs are checked after the edge.
    for (int i = 0; i < 13; i++) begin
      bus.Wr_en = vecs[i].wr; bus.Wr_addr = vecs[i].wa; bus.Wr_data = vecs[i].wd;
      bus.Iss_en = vecs[i].iss; bus.Iss_addr = vecs[i].ia;
      step();
      idle();
      set_rd(vecs[i].r0, vecs[i].r1);
      #1;
      check($sformatf("vec%0d_d0", i), bus.Rd_data[31:0], vecs[i].d0);
      check($sformatf("vec%0d_d1", i), bus.Rd_data[63:32], vecs[i].d1);
      check($sformatf("vec%0d_busy", i), {30'b0, bus.Rd_busy}, {30'b0, vecs[i].busy});
      check($sformatf("vec%0d_cnt", i), {26'b0, bus.Pend_cnt}, {26'b0, vecs[i].cnt});
      $display("vec %0d: wr=%0d x%0d=%0h iss=%0d x%0d -> d0=%0h d1=%0h busy=%b cnt=%0d",
               i, vecs[i].wr, vecs[i].wa, vecs[i].wd, vecs[i].iss, vecs[i].ia,
               bus.Rd_data[31:0], bus.Rd_data[63:32], bus.Rd_busy, bus.Pend_cnt);
    end

    // Same-cycle read of a register being written back while pending.
    bus.Iss_en = 1'b1; bus.Iss_addr = 5'd4;
    step();
    idle();
    set_rd(5'd4, 5'd4);
    bus.Wr_en = 1'b1; bus.Wr_addr = 5'd4; bus.Wr_data = 32'h0000CAFE;
    bus.Iss_en = 1'b1; bus.Iss_addr = 5'd4;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_same_data", bus.Rd_data[63:32], 32'h0000CAFE);
    check("byp_same_busy", {30'b0, bus.Rd_busy}, 32'd0);
`else
    check("byp_same_data", bus.Rd_data[63:32], 32'h0);
    check("byp_same_busy", {30'b0, bus.Rd_busy}, 32'd3);
`endif
    bus.Iss_en = 1'b0;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_same_data_noiss", bus.Rd_data[31:0], 32'h0000CAFE);
`else
    check("byp_same_data_noiss", bus.Rd_data[31:0], 32'h0);
`endif
    step();
    idle();
    #1;
    check("byp_next_data", bus.Rd_data[31:0], 32'h0000CAFE);
    check("byp_next_busy", {30'b0, bus.Rd_busy}, 32'd0);
    check("byp_next_cnt", {26'b0, bus.Pend_cnt}, 32'd0);
    $display("bypass: x4=%0h busy=%b cnt=%0d", bus.Rd_data[31:0], bus.Rd_busy, bus.Pend_cnt);

    // Reset while five registers are pending.
    for (int r = 20; r < 25; r++) begin
      bus.Iss_en = 1'b1; bus.Iss_addr = 5'(r);
      step();
    end
    idle();
    set_rd(5'd20, 5'd24);
    #1;
    check("pend5_cnt", {26'b0, bus.Pend_cnt}, 32'd5);
    check("pend5_busy", {30'b0, bus.Rd_busy}, 32'd3);
    Rst = 1'b1;
    step();
    check("midrst_cnt", {26'b0, bus.Pend_cnt}, 32'd0);
    check("midrst_busy", {30'b0, bus.Rd_busy}, 32'd0);
    check("midrst_ready", {31'b0, bus.Ready}, 32'd0);
    Rst = 1'b0;
    wait_ready(n);
    check("midrst_sweep_len", n, 32'd32);
    for (int r = 0; r < 32; r += 2) begin
      set_rd(5'(r), 5'(r + 1));
      #1;
      check($sformatf("clear_x%0d", r), bus.Rd_data[31:0], 32'd0);
      check($sformatf("clear_x%0d", r + 1), bus.Rd_data[63:32], 32'd0);
      check($sformatf("clear_busy_x%0d", r), {30'b0, bus.Rd_busy}, 32'd0);
    end
    $display("reset in run: sweep %0d cycles, cnt=%0d", n, bus.Pend_cnt);

    // Reset again at sweep cycle 10; the sweep must restart from entry 0.
    bus.Wr_en = 1'b1; bus.Wr_addr = 5'd31; bus.Wr_data = 32'h31;
    step();
    idle();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    for (int c = 0; c < 10; c++) step();
    check("sweep10_ready", {31'b0, bus.Ready}, 32'd0);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    wait_ready(n);
    check("resweep_len", n, 32'd32);
    set_rd(5'd31, 5'd0);
    #1;
    check("resweep_x31", bus.Rd_data[31:0], 32'd0);
    $display("reset mid-sweep: ready after %0d cycles", n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port integer register file with a write-back scoreboard, for the RISC-V core's decode/write-back stages. It stores N_REG registers of N_BIT bits and serves N_RD combinational reads. A pending-write bit per register flags operands whose producer has issued but not yet written back. A post-reset sweep clears storage one entry per cycle, so the array maps onto RAM without a global clear.

## Interface
- N_ADDR, 5: register address width.
- N_REG, 2**N_ADDR: number of registers.
- N_BIT, 32: data width per register.
- N_RD, 2: number of read ports, legal range 1..4.
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  synchronous, active-high reset.
- Rd_addr  in  N_RD*N_ADDR  read addresses; port i occupies bits [i*N_ADDR +: N_ADDR].
- Rd_data  out  N_RD*N_BIT  read data; port i occupies bits [i*N_BIT +: N_BIT].
- Rd_busy  out  N_RD  port i operand has a pending write.
- Wr_en  in  1  write-back strobe.
- Wr_addr  in  N_ADDR  write-back address.
- Wr_data  in  N_BIT  write-back data.
- Iss_en  in  1  issue strobe; marks Iss_addr pending.
- Iss_addr  in  N_ADDR  destination register of the issued instruction.
- Ready  out  1  sweep complete; block accepts writes and issues.
- Pend_cnt  out  N_ADDR+1  number of registers currently pending.

## Operation
- Register 0 is hardwired to zero:
  - Reads of address 0 return 0 with busy 0.
  - Writes and issues to address 0 are dropped.
- States: SWEEP and RUN.
  - Rst forces SWEEP with the sweep pointer at 0, and clears all pending bits and Pend_cnt.
  - In SWEEP, one cycle per register clears bank[ptr] to 0 and increments ptr. SWEEP lasts N_REG cycles after Rst falls, then moves to RUN.
  - Rst asserted mid-sweep restarts the sweep at 0.
- In SWEEP:
  - Ready is 0, Rd_data is all zeros, Rd_busy is 0.
  - Wr_en and Iss_en are ignored.
- In RUN, reads:
  - Rd_data[i] = bank[Rd_addr[i]].
  - Rd_busy[i] = pending[Rd_addr[i]].
- In RUN, write-back: Wr_en with Wr_addr != 0 writes bank[Wr_addr] and clears pending[Wr_addr].
- In RUN, issue: Iss_en with Iss_addr != 0 sets pending[Iss_addr].
- Simultaneous Iss_en and Wr_en to the same address: the register is written and pending ends up set (the new producer wins).
- Pend_cnt tracks the number of set pending bits exactly:
  - Increments only when a bit goes 0 to 1.
  - Decrements only when a bit goes 1 to 0.
  - Re-issuing an already-pending register leaves it unchanged.
  - A write-back to a non-pending register leaves it unchanged.
  - Never wraps; the maximum is N_REG-1.
- Multiple read ports may name the same address; each sees identical results.

## Timing
- Reads are combinational from the registered array and pending state; zero latency.
- Writes, issues, pending updates, Pend_cnt, the sweep pointer and state all update at the Clk rising edge.
- Values after reset:
  - Ready 0, Pend_cnt 0, Rd_busy 0, Rd_data 0.
  - Ready rises on the edge ending the N_REG-th sweep cycle after Rst deasserts.
- Without bypass:
  - A write at edge k is visible on reads after edge k.
  - An issue at edge k makes Rd_busy 1 after edge k.

## Configuration
- REGFILE_BYPASS_EN defined: write-to-read forwarding.
  - In RUN, if Wr_en and Wr_addr == Rd_addr[i] != 0, then Rd_data[i] = Wr_data and Rd_busy[i] = 0 in the same cycle.
  - A same-cycle Iss_en to that address does not affect this cycle's busy.
- REGFILE_BYPASS_EN undefined: reads see the pre-edge array and pending bits only; the same-cycle read returns old data and busy as stored.

## Test plan
- Sweep after reset:
  - Pulse Rst for 1 cycle, then read x5.
  - Ready must be 0 for exactly 32 cycles (N_REG=32), then 1; x5 reads 0 throughout.
  - Wr_en during the sweep has no effect: after Ready, x5 is still 0.
- Basic write and zero register:
  - Write 0xDEADBEEF to x7, then read x7 on port 0 and x0 on port 1.
  - Required: 0xDEADBEEF and 0.
  - Write 0x1234 to x0, then read x0: still 0.
- Scoreboard:
  - Issue x3: Rd_busy=1 on x3 next cycle, Pend_cnt=1.
  - Issue x3 again: Pend_cnt stays 1.
  - Write back x3=0x55: busy=0, Pend_cnt=0, read 0x55.
- Simultaneous issue and write-back:
  - Same cycle: Iss_addr=9 with Wr_addr=9, data 0xA5.
  - Required next cycle: x9 reads 0xA5, busy=1, Pend_cnt unchanged from before if x9 was already pending, else +1.
- Bypass:
  - Hold Rd_addr=4 while Wr_en writes x4=0xCAFE.
  - With REGFILE_BYPASS_EN: same cycle Rd_data=0xCAFE, busy=0.
  - Without REGFILE_BYPASS_EN: the old value is read that cycle and 0xCAFE the next.
- Reset mid-operation:
  - With 5 registers pending, assert Rst during RUN.
  - Required: Pend_cnt=0, all busy 0, Ready 0; then a full 32-cycle sweep, after which all registers read 0.
  - Also assert Rst at sweep cycle 10: the sweep restarts and Ready rises 32 cycles after Rst falls.
